// File: rtl/dmem_responder.sv
// Single-port data memory responder: accepts one load/store request, waits LATENCY
// cycles, then holds the response until the initiator consumes it.
module dmem_responder #(
   parameter int unsigned LATENCY     = 2,
   parameter int unsigned DEPTH_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [13:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_type,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [13:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  type_q, type_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem [DEPTH_WORDS];
   logic [AW-1:0] widx;
   logic [31:0] rd_word, ld_val, wlane;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [3:0]  be;
   logic        req_err, access, mem_we;

   assign widx    = AW'(32'(addr_q[13:2]) % DEPTH_WORDS);
   assign rd_word = mem[widx];
   assign byte_v  = 8'(rd_word >> {addr_q[1:0], 3'b000});
   assign half_v  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      req_err = 1'b0;
      case (type_q)
         3'b000, 3'b100: req_err = 1'b0;
         3'b001, 3'b101: req_err = addr_q[0];
         3'b010:         req_err = (addr_q[1:0] != 2'b00);
         default:        req_err = 1'b1;
      endcase
      if (we_q && type_q[2]) req_err = 1'b1;
   end

   always_comb begin
      ld_val = '0;
      be     = '0;
      wlane  = wdata_q;
      case (type_q)
         3'b000: begin
            ld_val = {{24{byte_v[7]}}, byte_v};
            be     = 4'b0001 << addr_q[1:0];
            wlane  = {4{wdata_q[7:0]}};
         end
         3'b001: begin
            ld_val = {{16{half_v[15]}}, half_v};
            be     = addr_q[1] ? 4'b1100 : 4'b0011;
            wlane  = {2{wdata_q[15:0]}};
         end
         3'b010: begin
            ld_val = rd_word;
            be     = 4'b1111;
         end
         3'b100:  ld_val = {24'b0, byte_v};
         3'b101:  ld_val = {16'b0, half_v};
         default: ld_val = '0;
      endcase
   end

   assign access = (state_q == S_WAIT) && (cnt_q == 4'd0);
   // rst gating keeps a store from landing when reset coincides with the access edge
   assign mem_we = access && we_q && !req_err && !rst;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      type_d  = type_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               type_d  = req_type;
               cnt_d   = 4'(LATENCY - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               err_d   = req_err;
               rdata_d = (req_err || we_q) ? '0 : ld_val;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         type_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         type_q  <= type_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE) && !rst;
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table of load/store vectors checked through a response
// scoreboard, plus hand sequences for reset, backpressure and reset-abort.
module tb_dmem_responder;

   localparam int unsigned LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [13:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_type = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   dmem_responder #(.LATENCY(LAT), .DEPTH_WORDS(4096)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        we;
      logic [13:0] addr;
      logic [31:0] wdata;
      logic [2:0]  typ;
      logic [31:0] exp_rd;
      logic        exp_err;
      string       name;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      string       name;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   acc_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input logic we, input logic [13:0] a, input logic [31:0] d,
                               input logic [2:0] t, input logic [31:0] er, input logic ee,
                               input string n);
      vec_t v;
      v.we = we; v.addr = a; v.wdata = d; v.typ = t;
      v.exp_rd = er; v.exp_err = ee; v.name = n;
      tbl.push_back(v);
   endfunction

   task automatic send(input logic we, input logic [13:0] a, input logic [31:0] d,
                       input logic [2:0] t, input bit push, input logic [31:0] er,
                       input logic ee, input string n);
      bit   seen = 0;
      exp_t e;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (req_ready) seen = 1;
      end
      if (!seen) chk({n, "_req_ready_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_type = t;
      if (push) begin
         e.rd = er; e.err = ee; e.name = n;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string n, output bit ok);
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (resp_valid) ok = 1;
      end
      if (!ok) chk({n, "_resp_timeout"}, 32'(resp_valid), 32'd1);
   endtask

   task automatic receive(input bit chk_lat);
      bit   ok;
      exp_t e;
      string n;
      n = (sb.size() != 0) ? sb[0].name : "empty_sb";
      wait_resp(n, ok);
      if (ok) begin
         if (chk_lat) chk({n, "_latency"}, 32'(cyc - acc_cyc), 32'(LAT));
         if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_rdata"}, resp_rdata, e.rd);
            chk({e.name, "_err"}, 32'(resp_err), 32'(e.err));
         end
         resp_ready = 1'b1;
         @(posedge clk);
         #1;
         resp_ready = 1'b0;
      end
   endtask

   initial begin
      bit ok;

      add(1, 14'h0010, 32'hDEADBEEF, 3'b010, 32'h0, 0, "sw_10");
      add(0, 14'h0010, 32'h0,        3'b010, 32'hDEADBEEF, 0, "lw_10");
      add(1, 14'h0020, 32'h80FF7F01, 3'b010, 32'h0, 0, "sw_20");
      add(0, 14'h0023, 32'h0,        3'b000, 32'hFFFFFF80, 0, "lb_23");
      add(0, 14'h0023, 32'h0,        3'b100, 32'h00000080, 0, "lbu_23");
      add(0, 14'h0020, 32'h0,        3'b001, 32'h00007F01, 0, "lh_20");
      add(0, 14'h0022, 32'h0,        3'b101, 32'h000080FF, 0, "lhu_22");
      add(0, 14'h0022, 32'h0,        3'b001, 32'hFFFF80FF, 0, "lh_22");
      add(0, 14'h0020, 32'h0,        3'b000, 32'h00000001, 0, "lb_20");
      add(1, 14'h0030, 32'h0,        3'b010, 32'h0, 0, "sw_30");
      add(1, 14'h0031, 32'h000000AA, 3'b000, 32'h0, 0, "sb_31");
      add(1, 14'h0032, 32'h00001234, 3'b001, 32'h0, 0, "sh_32");
      add(0, 14'h0030, 32'h0,        3'b010, 32'h1234AA00, 0, "lw_30");
      add(1, 14'h0040, 32'hCAFEF00D, 3'b010, 32'h0, 0, "sw_40");
      add(1, 14'h0041, 32'h0000FFFF, 3'b001, 32'h0, 1, "sh_41_misal");
      add(1, 14'h0040, 32'h00000055, 3'b100, 32'h0, 1, "sbu_store_illegal");
      add(1, 14'h0042, 32'h00000000, 3'b010, 32'h0, 1, "sw_42_misal");
      add(0, 14'h0040, 32'h0,        3'b010, 32'hCAFEF00D, 0, "lw_40_intact");
      add(0, 14'h0040, 32'h0,        3'b011, 32'h0, 1, "type_011");
      add(0, 14'h0040, 32'h0,        3'b110, 32'h0, 1, "type_110");
      add(0, 14'h0040, 32'h0,        3'b111, 32'h0, 1, "type_111");
      add(0, 14'h0022, 32'h0,        3'b010, 32'h0, 1, "lw_22_misal");
      add(1, 14'h3FFC, 32'hA5A5C3C3, 3'b010, 32'h0, 0, "sw_top");
      add(0, 14'h3FFE, 32'h0,        3'b101, 32'h0000A5A5, 0, "lhu_top");
      add(1, 14'h0050, 32'h22222222, 3'b010, 32'h0, 0, "sw_50_old");

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);

      foreach (tbl[i]) begin
         send(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].typ, 1,
              tbl[i].exp_rd, tbl[i].exp_err, tbl[i].name);
         receive(1);
      end

      // backpressure: response held, requests during RESP ignored
      send(0, 14'h0010, 32'h0, 3'b010, 1, 32'hDEADBEEF, 0, "bp_lw_10");
      wait_resp("bp_lw_10", ok);
      for (int k = 0; k < 5; k++) begin
         req_valid = 1'b1; req_we = 1'b1; req_addr = 14'h0010;
         req_wdata = 32'h0; req_type = 3'b010;
         @(negedge clk);
         chk("bp_resp_valid", 32'(resp_valid), 32'd1);
         chk("bp_rdata_stable", resp_rdata, 32'hDEADBEEF);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      receive(0);
      chk("bp_after_hs_valid", 32'(resp_valid), 32'd0);
      chk("bp_after_hs_ready", 32'(req_ready), 32'd1);
      send(0, 14'h0010, 32'h0, 3'b010, 1, 32'hDEADBEEF, 0, "lw_10_after_bp");
      receive(1);

      // reset while the store is at its access cycle
      send(1, 14'h0050, 32'h11111111, 3'b010, 0, 32'h0, 0, "sw_50_abort");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      send(0, 14'h0050, 32'h0, 3'b010, 1, 32'h22222222, 0, "lw_50_after_abort");
      receive(1);

      // reset during RESP discards the response
      send(0, 14'h0010, 32'h0, 3'b010, 0, 32'h0, 0, "lw_10_discard");
      wait_resp("lw_10_discard", ok);
      rst = 1'b1;
      #1;
      chk("resp_rst_valid", 32'(resp_valid), 32'd0);
      chk("resp_rst_rdata", resp_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("resp_rst_req_ready", 32'(req_ready), 32'd1);
      send(0, 14'h0020, 32'h0, 3'b010, 1, 32'h80FF7F01, 0, "lw_20_final");
      receive(1);

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
